matrix_link_sequencer: RTL and testbench

//  Parametrised serial-link sequencer for the matrix-multiply datapath. Streams NUM_IN
//  NxN operand matrices from the UART receiver into matrix memory, kicks the MAC array,

---
 rtl/matrix_link_sequencer_if.sv | 19 +
 rtl/matrix_link_sequencer.sv | 92 +++++++++
 tb/tb_matrix_link_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_link_sequencer_if.sv
// matrix_link_sequencer_if: bus bundle linking the sequencer to the UART rx/tx, matrix RAM and MAC unit
// master (sequencer side) inputs : start, abort, rx_valid, rx_data, rd_data, mac_done, tx_ready
// master (sequencer side) outputs: wr_en, wr_data, mat_sel, row, col, mac_start, tx_valid, tx_data, busy, frame_done
// slave is the mirror view used by the surrounding environment
interface matrix_link_sequencer_if #(parameter int DW = 8, parameter int IDX_W = 4);
  logic start, abort, rx_valid, mac_done, tx_ready;
  logic [DW-1:0] rx_data, rd_data, wr_data, tx_data;
  logic wr_en, mac_start, tx_valid, busy, frame_done;
  logic [1:0] mat_sel;
  logic [IDX_W-1:0] row, col;
  modport master (
    input start, abort, rx_valid, rx_data, rd_data, mac_done, tx_ready,
    output wr_en, wr_data, mat_sel, row, col, mac_start, tx_valid, tx_data, busy, frame_done
  );
  modport slave (
    output start, abort, rx_valid, rx_data, rd_data, mac_done, tx_ready,
    input wr_en, wr_data, mat_sel, row, col, mac_start, tx_valid, tx_data, busy, frame_done
  );
endinterface

// File: rtl/matrix_link_sequencer.sv
// matrix_link_sequencer: loads NUM_IN NxN operands from UART rx into RAM, kicks the MAC, streams the result to UART tx
// clk   : system clock, rising edge
// reset : asynchronous active-high reset
// bus   : matrix_link_sequencer_if.master (rx stream, RAM write/read port, MAC start/done, tx handshake, status)
module matrix_link_sequencer #(
  parameter int DW = 8,
  parameter int N = 10,
  parameter int NUM_IN = 2,
  parameter int IDX_W = 4
) (
  input logic clk,
  input logic reset,
  matrix_link_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, KICK, CALC, RADDR, RDATA, TX, FIN} state_t;
  state_t state, state_nx;
  logic [1:0] m, sel;
  logic [IDX_W-1:0] r, c, r_nx, c_nx, row_q, col_q;
  logic [DW-1:0] wr_data_q, tx_data_q;
  logic wr_en_q, c_last, r_last, loaded, take, hs;
  assign c_last = c == IDX_W'(N - 1);
  assign r_last = r == IDX_W'(N - 1);
  assign c_nx = c_last ? '0 : c + 1'b1;
  assign r_nx = c_last ? (r_last ? '0 : r + 1'b1) : r;
  // m reaches NUM_IN once the final operand byte is captured; LOAD then spends one more cycle writing it
  assign loaded = m == 2'(NUM_IN);
  assign take = state == LOAD && bus.rx_valid && !loaded;
  assign hs = state == TX && bus.tx_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = bus.start ? LOAD : IDLE;
      LOAD:  state_nx = loaded ? KICK : LOAD;
      KICK:  state_nx = CALC;
      CALC:  state_nx = bus.mac_done ? RADDR : CALC;
      RADDR: state_nx = RDATA;
      RDATA: state_nx = TX;
      TX:    state_nx = !bus.tx_ready ? TX : (r_last && c_last) ? FIN : RADDR;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort) state_nx = IDLE;
  end
  // write address is registered separately because the counters already point past the byte being written
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {m, sel, r, c, row_q, col_q} <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      wr_en_q <= 1'b0;
    end else if (bus.abort) begin
      {m, sel, r, c, row_q, col_q} <= '0;
      wr_en_q <= 1'b0;
    end else begin
      wr_en_q <= take;
      if (state == IDLE && bus.start) {m, r, c} <= '0;
      if (take) begin
        wr_data_q <= bus.rx_data;
        sel <= m;
        row_q <= r;
        col_q <= c;
        m <= m + 2'(c_last && r_last);
        r <= r_nx;
        c <= c_nx;
      end
      if (state == CALC && bus.mac_done) begin
        m <= 2'(NUM_IN);
        sel <= 2'(NUM_IN);
        {r, c, row_q, col_q} <= '0;
      end
      if (state == RDATA) tx_data_q <= bus.rd_data;
      if (hs) begin
        r <= r_nx;
        c <= c_nx;
        row_q <= r_nx;
        col_q <= c_nx;
      end
    end
  assign bus.wr_en = wr_en_q;
  assign bus.wr_data = wr_data_q;
  assign bus.mat_sel = sel;
  assign bus.row = row_q;
  assign bus.col = col_q;
  assign bus.mac_start = state == KICK;
  assign bus.tx_valid = state == TX;
  assign bus.tx_data = tx_data_q;
  assign bus.busy = state != IDLE;
  assign bus.frame_done = state == FIN;
endmodule

// File: tb/tb_matrix_link_sequencer.sv
// tb_matrix_link_sequencer: directed self-checking bench for matrix_link_sequencer with N=2, NUM_IN=2
module tb_matrix_link_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  logic [7:0] exp_tx [4] = '{8'd0, 8'd1, 8'd8, 8'd9};
  logic [30:0] outs;
  logic [18:0] wv;
  always #5 clk = ~clk;
  matrix_link_sequencer_if #(.DW(8), .IDX_W(4)) bus();
  matrix_link_sequencer #(.DW(8), .N(2), .NUM_IN(2), .IDX_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  // result RAM: one-cycle read latency, content 8*row+col
  always @(posedge clk) bus.rd_data <= 8'(8 * bus.row + bus.col);
  assign outs = {bus.busy, bus.wr_en, bus.mac_start, bus.tx_valid, bus.frame_done,
                 bus.mat_sel, bus.row, bus.col, bus.wr_data, bus.tx_data};
  assign wv = {bus.wr_en, bus.wr_data, bus.mat_sel, bus.row, bus.col};

  task automatic test_reset();
    {bus.start, bus.abort, bus.rx_valid, bus.mac_done, bus.tx_ready} = '0;
    bus.rx_data = '0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (outs !== 31'd0) $display("FAIL reset_outputs: got %h want 0", outs); else passed++;
    reset = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h77;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    total++;
    if ({bus.busy, bus.wr_en} !== 2'b00) $display("FAIL idle_rx_ignored: got %b want 00", {bus.busy, bus.wr_en}); else passed++;
  endtask

  task automatic test_load_back_to_back();
    logic [18:0] want;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) $display("FAIL load_busy: got %b want 1", bus.busy); else passed++;
    for (int i = 0; i < 8; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'(i + 1);
      @(negedge clk);
      want = {1'b1, 8'(i + 1), 2'(i >> 2), 4'((i >> 1) & 1), 4'(i & 1)};
      total++;
      if (wv !== want) $display("FAIL b2b_write%0d: got %h want %h", i, wv, want); else passed++;
    end
    bus.rx_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.mac_start, bus.wr_en} !== 2'b10) $display("FAIL kick_pulse: got %b want 10", {bus.mac_start, bus.wr_en}); else passed++;
    @(negedge clk);
    total++;
    if ({bus.mac_start, bus.wr_en, bus.busy} !== 3'b001) $display("FAIL kick_single: got %b want 001", {bus.mac_start, bus.wr_en, bus.busy}); else passed++;
  endtask

  task automatic test_compute_tx();
    int n = 0, last = 0, fd = 0;
    logic [7:0] want;
    bus.tx_ready = 1'b1;
    repeat (19) @(negedge clk);
    total++;
    if ({bus.busy, bus.tx_valid} !== 2'b10) $display("FAIL calc_wait: got %b want 10", {bus.busy, bus.tx_valid}); else passed++;
    bus.mac_done = 1'b1;
    @(negedge clk);
    bus.mac_done = 1'b0;
    for (int cyc = 0; cyc < 60 && fd == 0; cyc++) begin
      @(negedge clk);
      if (bus.tx_valid) begin
        want = n < 4 ? exp_tx[n] : 8'hFF;
        total++;
        if ({bus.tx_data, bus.mat_sel} !== {want, 2'd2}) $display("FAIL tx_byte%0d: got %h want %h", n, {bus.tx_data, bus.mat_sel}, {want, 2'd2}); else passed++;
        if (n > 0) begin
          total++;
          if (cyc - last !== 3) $display("FAIL tx_spacing%0d: got %0d want 3", n, cyc - last); else passed++;
        end
        last = cyc;
        n++;
      end
      if (bus.frame_done) fd++;
    end
    total++;
    if (n !== 4) $display("FAIL tx_count: got %0d want 4", n); else passed++;
    total++;
    if (fd !== 1) $display("FAIL frame_done: got %0d want 1", fd); else passed++;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.frame_done, bus.tx_valid} !== 3'b000) $display("FAIL fin_idle: got %b want 000", {bus.busy, bus.frame_done, bus.tx_valid}); else passed++;
  endtask

  task automatic test_load_gapped();
    int spurious = 0;
    logic [18:0] want;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'(8'h10 + i);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      want = {1'b1, 8'(8'h10 + i), 2'(i >> 2), 4'((i >> 1) & 1), 4'(i & 1)};
      total++;
      if (wv !== want) $display("FAIL gap_write%0d: got %h want %h", i, wv, want); else passed++;
      if (i < 7) repeat (4) begin
        @(negedge clk);
        if (bus.wr_en !== 1'b0) spurious++;
      end
    end
    total++;
    if (spurious !== 0) $display("FAIL gap_no_write: got %0d extra strobes want 0", spurious); else passed++;
    @(negedge clk);
    total++;
    if ({bus.mac_start, bus.wr_en} !== 2'b10) $display("FAIL gap_kick: got %b want 10", {bus.mac_start, bus.wr_en}); else passed++;
    @(negedge clk);
    total++;
    if (bus.mac_start !== 1'b0) $display("FAIL gap_kick_single: got %b want 0", bus.mac_start); else passed++;
  endtask

  task automatic test_tx_stall();
    int n = 0, held = 0, bad = 0, fd = 0;
    logic [7:0] want;
    bus.tx_ready = 1'b1;
    bus.mac_done = 1'b1;
    @(negedge clk);
    bus.mac_done = 1'b0;
    for (int cyc = 0; cyc < 80 && fd == 0; cyc++) begin
      @(negedge clk);
      if (bus.tx_valid && n == 1) begin
        if (bus.tx_data !== 8'd1) bad++;
        held++;
        if (held == 7) begin
          bus.tx_ready = 1'b1;
          n++;
        end
      end else if (bus.tx_valid) begin
        want = n < 4 ? exp_tx[n] : 8'hFF;
        total++;
        if (bus.tx_data !== want) $display("FAIL stall_byte%0d: got %h want %h", n, bus.tx_data, want); else passed++;
        n++;
      end else begin
        if (n == 1 && held > 0) bad++;
        bus.tx_ready = n != 1;
      end
      if (bus.frame_done) fd = 1;
    end
    bus.tx_ready = 1'b1;
    total++;
    if (held !== 7) $display("FAIL stall_held: got %0d want 7", held); else passed++;
    total++;
    if (bad !== 0) $display("FAIL stall_stable: got %0d glitches want 0", bad); else passed++;
    total++;
    if (n !== 4 || fd !== 1) $display("FAIL stall_complete: got n=%0d fd=%0d want 4 1", n, fd); else passed++;
    @(negedge clk);
  endtask

  task automatic test_abort_load();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'(8'hA0 + i);
      @(negedge clk);
    end
    bus.abort = 1'b1;
    bus.rx_data = 8'hEE;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.rx_valid = 1'b0;
    total++;
    if ({bus.busy, bus.wr_en, bus.mac_start, bus.tx_valid} !== 4'b0000) $display("FAIL abort_idle: got %b want 0000", {bus.busy, bus.wr_en, bus.mac_start, bus.tx_valid}); else passed++;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL abort_beats_start: got %b want 0", bus.busy); else passed++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h55;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    total++;
    if (wv !== {1'b1, 8'h55, 10'd0}) $display("FAIL reload_first: got %h want %h", wv, {1'b1, 8'h55, 10'd0}); else passed++;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++;
    if ({bus.busy, bus.wr_en} !== 2'b00) $display("FAIL abort_again: got %b want 00", {bus.busy, bus.wr_en}); else passed++;
  endtask

  task automatic test_reset_midframe();
    int spurious = 0, found = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'(i);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.wr_en !== 1'b0) spurious++;
    end
    bus.rx_valid = 1'b0;
    total++;
    if (spurious !== 0) $display("FAIL calc_rx_ignored: got %0d writes want 0", spurious); else passed++;
    total++;
    if ({bus.busy, bus.tx_valid, bus.mac_start} !== 3'b100) $display("FAIL calc_hold: got %b want 100", {bus.busy, bus.tx_valid, bus.mac_start}); else passed++;
    bus.tx_ready = 1'b0;
    bus.mac_done = 1'b1;
    @(negedge clk);
    bus.mac_done = 1'b0;
    for (int cyc = 0; cyc < 10 && found == 0; cyc++) begin
      @(negedge clk);
      if (bus.tx_valid) found = 1;
    end
    total++;
    if (found !== 1) $display("FAIL reach_tx: tx_valid not seen within 10 cycles"); else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (outs !== 31'd0) $display("FAIL async_reset: got %h want 0", outs); else passed++;
    @(negedge clk);
    reset = 1'b0;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.tx_valid, bus.frame_done} !== 3'b000) $display("FAIL post_reset_idle: got %b want 000", {bus.busy, bus.tx_valid, bus.frame_done}); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_back_to_back();
    test_compute_tx();
    test_load_gapped();
    test_tx_stall();
    test_abort_load();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
